// File: rtl/resp_framer_if.sv
// Bundles the two handshakes around the response framer: result intake
// from the ALU side and the byte stream towards the UART transmitter.
// Names carry the framer's point of view (_i into the framer, _o out of it).
interface resp_framer_if #(
    parameter int MAX_BYTES = 8
);
    logic [7:0]             opcode_i;
    logic [8*MAX_BYTES-1:0] result_i;
    logic [3:0]             nbytes_i;
    logic                   valid_i;
    logic                   ready_o;
    logic [7:0]             data_o;
    logic                   valid_o;
    logic                   ready_i;
    logic                   busy_o;

    // Framer side.
    modport slave (
        input  opcode_i, result_i, nbytes_i, valid_i, ready_i,
        output ready_o, data_o, valid_o, busy_o
    );

    // Producer/consumer side (ALU feeding results, UART draining bytes).
    modport master (
        output opcode_i, result_i, nbytes_i, valid_i, ready_i,
        input  ready_o, data_o, valid_o, busy_o
    );
endinterface

// File: rtl/resp_framer.sv
// Response framer: latches one result and emits it as
// opcode, reserved, len_lsb, len_msb, payload (LSB first).
// All outputs come straight from registers, so nothing on the TX side
// depends combinationally on any input.
module resp_framer #(
    parameter int         MAX_BYTES = 8,
    parameter logic [7:0] RSVD_BYTE = 8'h00
) (
    input  logic          clk,
    input  logic          rst_n,
    resp_framer_if.slave  bus
);
    localparam int CW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int NW = $clog2(MAX_BYTES + 1);

    typedef enum logic [2:0] {
        IDLE, HDR_OP, HDR_RSV, HDR_LSB, HDR_MSB, DATA
    } state_t;

    state_t                 state_q;
    logic [7:0]             op_q;
    logic [8*MAX_BYTES-1:0] res_q;
    logic [NW-1:0]          n_q;
    logic [CW-1:0]          cnt_q;
    logic                   valid_q;
    logic [7:0]             data_q;
    logic                   ready_q;
    logic                   busy_q;

    logic [NW-1:0]          n_d;
    logic [CW-1:0]          cnt_d;
    logic [15:0]            len_d;
    logic                   tx_fire;
    logic                   last_data;
    logic [7:0]             byte_w [MAX_BYTES];

    // Split the latched result word into addressable bytes.
    generate
        for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_bytes
            assign byte_w[gi] = res_q[8*gi +: 8];
        end
    endgenerate

    // Clamp the requested count, derive frame length and transfer/last flags.
    always_comb begin
        n_d       = (32'(bus.nbytes_i) > MAX_BYTES) ? NW'(MAX_BYTES) : NW'(bus.nbytes_i);
        cnt_d     = cnt_q + CW'(1);
        len_d     = 16'd4 + 16'(n_q);
        tx_fire   = valid_q && bus.ready_i;
        last_data = (NW'(cnt_q) == (n_q - NW'(1)));
    end

    // Frame sequencer; each output byte is preloaded into data_q on the
    // transfer that retires the previous one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            res_q   <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid_i && ready_q) begin
                        op_q    <= bus.opcode_i;
                        res_q   <= bus.result_i;
                        n_q     <= n_d;
                        cnt_q   <= '0;
                        data_q  <= bus.opcode_i;
                        valid_q <= 1'b1;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= HDR_OP;
                    end
                end
                HDR_OP: begin
                    if (tx_fire) begin
                        data_q  <= RSVD_BYTE;
                        state_q <= HDR_RSV;
                    end
                end
                HDR_RSV: begin
                    if (tx_fire) begin
                        data_q  <= len_d[7:0];
                        state_q <= HDR_LSB;
                    end
                end
                HDR_LSB: begin
                    if (tx_fire) begin
                        data_q  <= len_d[15:8];
                        state_q <= HDR_MSB;
                    end
                end
                HDR_MSB: begin
                    if (tx_fire) begin
                        if (n_q != '0) begin
                            cnt_q   <= '0;
                            data_q  <= byte_w[0];
                            state_q <= DATA;
                        end else begin
                            data_q  <= 8'h00;
                            valid_q <= 1'b0;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tx_fire) begin
                        if (last_data) begin
                            cnt_q   <= '0;
                            data_q  <= 8'h00;
                            valid_q <= 1'b0;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q  <= cnt_d;
                            data_q <= byte_w[cnt_d];
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.ready_o = ready_q;
    assign bus.busy_o  = busy_q;
endmodule

// File: tb/tb_resp_framer.sv
// Directed bench for resp_framer: drives results, drains the TX stream
// with configurable back-pressure and compares every byte to hand-written frames.
module tb_resp_framer;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_q [$];

    resp_framer_if #(.MAX_BYTES(8)) bus ();

    resp_framer #(.MAX_BYTES(8), .RSVD_BYTE(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one result for a single accepting edge (called at a negedge).
    task automatic send(input logic [7:0] op, input logic [63:0] res, input logic [3:0] nb);
        chk("accept_ready", {31'b0, bus.ready_o}, 32'd1);
        bus.opcode_i = op;
        bus.result_i = res;
        bus.nbytes_i = nb;
        bus.valid_i  = 1'b1;
        @(negedge clk);
        bus.valid_i  = 1'b0;
        chk("first_valid", {31'b0, bus.valid_o}, 32'd1);
        $display("send op=%02h res=%016h nbytes=%0d", op, res, nb);
    endtask

    // Drain one frame; mode 0 = ready always high, mode 1 = ready 1,0,0 repeating.
    task automatic recv(input string tag, input int mode);
        int idx = 0;
        int gaps = 0;
        int bad_rdy = 0;
        logic prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (prev_stall) begin
                chk({tag, "_stall_valid"}, {31'b0, bus.valid_o}, 32'd1);
                chk({tag, "_stall_data"}, {24'b0, bus.data_o}, {24'b0, prev_data});
            end
            if (!bus.valid_o) gaps++;
            if (bus.ready_o || !bus.busy_o) bad_rdy++;
            bus.ready_i = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            prev_stall  = bus.valid_o && !bus.ready_i;
            prev_data   = bus.data_o;
            if (bus.valid_o && bus.ready_i) begin
                if (idx < exp_q.size())
                    chk($sformatf("%s_byte%0d", tag, idx), {24'b0, bus.data_o}, {24'b0, exp_q[idx]});
                idx++;
                if (idx == exp_q.size()) break;
            end
            @(negedge clk);
        end
        chk({tag, "_count"}, idx, exp_q.size());
        chk({tag, "_gaps"}, gaps, 32'd0);
        chk({tag, "_rdy_busy"}, bad_rdy, 32'd0);
        @(negedge clk);
        chk({tag, "_end_valid"}, {31'b0, bus.valid_o}, 32'd0);
        chk({tag, "_end_ready"}, {31'b0, bus.ready_o}, 32'd1);
        chk({tag, "_end_busy"}, {31'b0, bus.busy_o}, 32'd0);
        $display("frame %s bytes=%0d mode=%0d", tag, idx, mode);
    endtask

    initial begin
        bus.opcode_i = 8'h00;
        bus.result_i = 64'h0;
        bus.nbytes_i = 4'd0;
        bus.valid_i  = 1'b0;
        bus.ready_i  = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", {31'b0, bus.valid_o}, 32'd0);
        chk("rst_data", {24'b0, bus.data_o}, 32'd0);
        chk("rst_ready", {31'b0, bus.ready_o}, 32'd1);
        chk("rst_busy", {31'b0, bus.busy_o}, 32'd0);
        $display("reset checked");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: basic 4-byte payload, no back-pressure
        send(8'h02, 64'h0000_0000_DEAD_BEEF, 4'd4);
        exp_q = '{8'h02, 8'h00, 8'h08, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        recv("t1", 0);

        // 2: same frame under 1,0,0 back-pressure
        send(8'h02, 64'h0000_0000_DEAD_BEEF, 4'd4);
        recv("t2", 1);

        // 3: header-only frame
        send(8'h00, 64'h1122_3344_5566_7788, 4'd0);
        exp_q = '{8'h00, 8'h00, 8'h04, 8'h00};
        recv("t3", 0);

        // 4: count above maximum is clamped to 8
        send(8'h33, 64'h0807_0605_0403_0201, 4'd9);
        exp_q = '{8'h33, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                  8'h05, 8'h06, 8'h07, 8'h08};
        recv("t4", 0);

        // 5: asynchronous reset in DATA with cnt=2
        send(8'h02, 64'h0000_0000_DEAD_BEEF, 4'd4);
        for (int i = 0; i < 6; i++) begin
            bus.ready_i = 1'b1;
            @(negedge clk);
        end
        bus.ready_i = 1'b0;
        chk("t5_pre_data", {24'b0, bus.data_o}, 32'hAD);
        chk("t5_pre_valid", {31'b0, bus.valid_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", {31'b0, bus.valid_o}, 32'd0);
        chk("t5_async_busy", {31'b0, bus.busy_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_rel_ready", {31'b0, bus.ready_o}, 32'd1);
        $display("reset mid-frame checked");
        @(negedge clk);
        send(8'h07, 64'h0000_0000_0000_005A, 4'd1);
        exp_q = '{8'h07, 8'h00, 8'h05, 8'h00, 8'h5A};
        recv("t5", 0);

        // 6: second result held valid during the first frame
        send(8'h11, 64'h0000_0000_0000_1234, 4'd2);
        bus.opcode_i = 8'h22;
        bus.result_i = 64'h0000_0000_0000_00CC;
        bus.nbytes_i = 4'd1;
        bus.valid_i  = 1'b1;
        exp_q = '{8'h11, 8'h00, 8'h06, 8'h00, 8'h34, 8'h12};
        recv("t6a", 1);
        @(negedge clk);
        bus.valid_i = 1'b0;
        chk("t6b_accept_valid", {31'b0, bus.valid_o}, 32'd1);
        exp_q = '{8'h22, 8'h00, 8'h05, 8'h00, 8'hCC};
        recv("t6b", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
